// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and launch FSM states.
package uart_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } feed_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is read combinationally so the
// consumer can capture it on the same edge that pops it.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = BYTE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [WIDTH-1:0]    din,
   input  logic                pop,
   input  logic                flush,
   output logic [WIDTH-1:0]    dout,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                empty
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push, w_pop;

   // flush wins over both ports; a write while full is simply ignored here
   assign w_push = push & ~full & ~flush;
   assign w_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr_ptr] <= din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
         else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == FULL_CNT);
   assign empty = (r_count == '0);
endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter; holds tx_data for the
// whole frame and flags starts that the transmitter never acknowledged.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2    = 4,
   parameter int BUSY_WAIT_MAX = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [BYTE_W-1:0]   wr_data,
   input  logic                flush,
   output logic                wr_full,
   output logic [DEPTH_LOG2:0] wr_count,
   output logic                overflow,
   output logic                launch_err,
   output logic                tx_start,
   output logic [BYTE_W-1:0]   tx_data,
   input  logic                tx_busy,
   output logic                idle
);
   localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   feed_state_e       r_state, w_next;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;
   logic              r_tx_start, r_overflow, r_launch_err;
   logic [BYTE_W-1:0] r_tx_data;
   logic [BYTE_W-1:0] w_head;
   logic              w_empty, w_pop, w_err_set;

   uart_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BYTE_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .din   (wr_data),
      .pop   (w_pop),
      .flush (flush),
      .dout  (w_head),
      .count (wr_count),
      .full  (wr_full),
      .empty (w_empty)
   );

   always_comb begin
      w_next     = r_state;
      w_wait_nxt = r_wait;
      w_pop      = 1'b0;
      w_err_set  = 1'b0;
      case (r_state)
         // tx_busy high here also covers a frame still running across our reset
         IDLE: if (!w_empty && !tx_busy && !flush) begin
            w_pop  = 1'b1;
            w_next = START;
         end
         START: begin
            w_wait_nxt = '0;
            w_next     = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_busy) begin
               w_next = WAIT_LO;
            end else if (r_wait == WAIT_LAST) begin
               w_err_set = 1'b1;
               w_next    = IDLE;
            end else begin
               w_wait_nxt = r_wait + WAIT_ONE;
            end
         end
         WAIT_LO: if (!tx_busy) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_wait       <= '0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_overflow   <= 1'b0;
         r_launch_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_wait     <= w_wait_nxt;
         r_tx_start <= w_pop;
         if (w_pop) r_tx_data <= w_head;
         if (w_err_set) r_launch_err <= 1'b1;
         if (wr_en && wr_full && !flush) r_overflow <= 1'b1;
      end
   end

   assign tx_start   = r_tx_start;
   assign tx_data    = r_tx_data;
   assign overflow   = r_overflow;
   assign launch_err = r_launch_err;
   assign idle       = w_empty && (r_state == IDLE);
endmodule
